// File: rtl/bzone_input_pkg.sv
// rtl/bzone_input_pkg.sv - shared constants, coin FSM states and tread map for bzone_input_cond
package bzone_input_pkg;

   localparam logic [7:0] MOD_BATTLEZONE = 8'd0;
   localparam logic [7:0] MOD_BRADLEY    = 8'd1;
   localparam logic [7:0] MOD_REDBARON   = 8'd2;

   localparam int JOY_R  = 0;
   localparam int JOY_L  = 1;
   localparam int JOY_D  = 2;
   localparam int JOY_U  = 3;
   localparam int JOY_F  = 4;
   localparam int JOY_S1 = 5;
   localparam int JOY_S2 = 6;
   localparam int JOY_C  = 7;

   typedef enum logic [1:0] {
      COIN_IDLE     = 2'd0,
      COIN_PULSE    = 2'd1,
      COIN_WAIT_REL = 2'd2
   } coin_state_t;

   // {u,d,l,r} -> {WF,WB,XF,XB}; diagonals and opposing pairs outside the table stop both treads
   function automatic logic [3:0] tread_map(input logic [3:0] udlr);
      logic [3:0] t;
      case (udlr)
         4'b1010: t = 4'b0010;
         4'b1000: t = 4'b1010;
         4'b1001: t = 4'b1000;
         4'b0001: t = 4'b1001;
         4'b0101: t = 4'b0100;
         4'b0100: t = 4'b0101;
         4'b0110: t = 4'b0001;
         4'b0010: t = 4'b0110;
         default: t = 4'b0000;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/input_debounce.sv
// rtl/input_debounce.sv - single-bit debouncer, output follows input after DEB_CYCLES stable cycles
module input_debounce #(
   parameter int DEB_CYCLES = 50000
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   localparam int              CW      = $clog2(DEB_CYCLES + 1);
   localparam logic [CW-1:0]   CNT_MAX = CW'(DEB_CYCLES);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          deb_q, deb_d;

   always_comb begin
      cnt_d = '0;
      deb_d = deb_q;
      if (d_i != deb_q) begin
         if (cnt_q + CW'(1) == CNT_MAX) begin
            deb_d = d_i;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
         deb_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         deb_q <= deb_d;
      end
   end

   assign q_o = deb_q;

endmodule

// File: rtl/bzone_input_cond.sv
// rtl/bzone_input_cond.sv - joystick/analog conditioning into Battlezone/Bradley/Red Baron switch buses
module bzone_input_cond
   import bzone_input_pkg::*;
#(
   parameter int DEB_CYCLES  = 50000,
   parameter int COIN_CYCLES = 2500000
) (
   input  logic        clk_i,
   input  logic        btnCpuReset,
   input  logic [15:0] joy_i,
   input  logic [15:0] joya_i,
   input  logic [7:0]  mod_i,
   input  logic [7:0]  audiosel_i,
   output logic [7:0]  JB_o,
   output logic [7:0]  buttons_o,
   output logic [7:0]  rb_buttons_o
);

   localparam int            CCW       = $clog2(COIN_CYCLES + 1);
   localparam logic [CCW-1:0] COIN_LOAD = CCW'(COIN_CYCLES - 1);

   logic [7:0]     sync1_q, sync2_q;
   logic [7:0]     deb;
   logic           r, l, d, u, f, s1, s2, c;
   logic [3:0]     tread;
   logic [7:0]     axis;
   coin_state_t    coin_state_q;
   logic [CCW-1:0] coin_cnt_q;
   logic           c_prev_q;
   logic [7:0]     mod_q;
   logic           mod_chg;
   logic           coin_act;
   logic [7:0]     jb_d, buttons_d, rb_d;
   logic           unused_bits;

   assign unused_bits = ^{joy_i[15:8], audiosel_i[7:1]};

   always_ff @(posedge clk_i or negedge btnCpuReset) begin
      if (!btnCpuReset) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= joy_i[7:0];
         sync2_q <= sync1_q;
      end
   end

   for (genvar i = 0; i < 8; i++) begin : g_deb
      input_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
         .clk_i  (clk_i),
         .rst_ni (btnCpuReset),
         .d_i    (sync2_q[i]),
         .q_o    (deb[i])
      );
   end

   assign r  = deb[JOY_R];
   assign l  = deb[JOY_L];
   assign d  = deb[JOY_D];
   assign u  = deb[JOY_U];
   assign f  = deb[JOY_F];
   assign s1 = deb[JOY_S1];
   assign s2 = deb[JOY_S2];
   assign c  = deb[JOY_C];

   assign tread = tread_map({u, d, l, r});

   // A game switch cancels any pulse in flight in the same cycle so the new mapping never sees it
   assign mod_chg  = (mod_i != mod_q);
   assign coin_act = (coin_state_q == COIN_PULSE) && !mod_chg;

   always_ff @(posedge clk_i or negedge btnCpuReset) begin
      if (!btnCpuReset) begin
         coin_state_q <= COIN_IDLE;
         coin_cnt_q   <= '0;
         c_prev_q     <= 1'b0;
         mod_q        <= '0;
      end else begin
         c_prev_q <= c;
         mod_q    <= mod_i;
         if (mod_chg) begin
            coin_state_q <= COIN_WAIT_REL;
         end else begin
            case (coin_state_q)
               COIN_IDLE: begin
                  if (c && !c_prev_q) begin
                     coin_state_q <= COIN_PULSE;
                     coin_cnt_q   <= COIN_LOAD;
                  end
               end
               COIN_PULSE: begin
                  if (coin_cnt_q == '0) begin
                     coin_state_q <= COIN_WAIT_REL;
                  end else begin
                     coin_cnt_q <= coin_cnt_q - CCW'(1);
                  end
               end
               COIN_WAIT_REL: begin
                  if (!c) begin
                     coin_state_q <= COIN_IDLE;
                  end
               end
               default: coin_state_q <= COIN_IDLE;
            endcase
         end
      end
   end

   assign axis = audiosel_i[0] ? joya_i[7:0] : joya_i[15:8];

   always_comb begin
      jb_d      = {coin_act, s1, s2, f, tread};
      buttons_d = {2'b00, s1, s2 | f, tread};
      rb_d      = 8'h00;
      case (mod_i)
         MOD_BATTLEZONE, MOD_BRADLEY: ;
         MOD_REDBARON: begin
            // Red Baron coin is active-low; the analog axis is offset to unsigned 0..255
            jb_d      = {~coin_act, s1, s2, f, d, u, r, l};
            rb_d      = {f, s1, 6'b000000};
            buttons_d = axis + 8'd128;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge btnCpuReset) begin
      if (!btnCpuReset) begin
         JB_o         <= '0;
         buttons_o    <= '0;
         rb_buttons_o <= '0;
      end else begin
         JB_o         <= jb_d;
         buttons_o    <= buttons_d;
         rb_buttons_o <= rb_d;
      end
   end

endmodule

// File: tb/tb_bzone_input_cond.sv
// tb/tb_bzone_input_cond.sv - scoreboard bench for bzone_input_cond with DEB_CYCLES=4, COIN_CYCLES=8
module tb_bzone_input_cond;

   typedef struct {
      int         cyc;
      string      nm;
      int         kind;
      logic [7:0] exp;
   } chk_t;

   localparam int K_JB = 0, K_BTN = 1, K_RB = 2, K_PULSES = 3, K_HIGH = 4;

   logic        clk;
   logic        rst_n;
   logic [15:0] joy;
   logic [15:0] joya;
   logic [7:0]  mod;
   logic [7:0]  audiosel;
   logic [7:0]  jb, btn, rbb;

   int          cyc;
   int          n_checks;
   int          n_fail;
   chk_t        sb[$];
   logic        coin_watch;
   logic        coin_prev;
   logic [7:0]  pulses;
   logic [7:0]  high_cnt;

   bzone_input_cond #(.DEB_CYCLES(4), .COIN_CYCLES(8)) dut (
      .clk_i        (clk),
      .btnCpuReset  (rst_n),
      .joy_i        (joy),
      .joya_i       (joya),
      .mod_i        (mod),
      .audiosel_i   (audiosel),
      .JB_o         (jb),
      .buttons_o    (btn),
      .rb_buttons_o (rbb)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc = cyc + 1;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached with %0d checks pending", sb.size());
      $fatal(1, "watchdog");
   end

   // Monitor: counts coin pulses on JB_o[7] and retires every scoreboard entry due this cycle
   initial begin
      logic [7:0] act;
      n_checks = 0;
      n_fail   = 0;
      pulses   = 8'd0;
      high_cnt = 8'd0;
      coin_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (coin_watch) begin
            if (jb[7] && !coin_prev) pulses = pulses + 8'd1;
            if (jb[7]) high_cnt = high_cnt + 8'd1;
         end
         coin_prev = jb[7];
         for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= cyc) begin
               case (sb[i].kind)
                  K_JB:     act = jb;
                  K_BTN:    act = btn;
                  K_RB:     act = rbb;
                  K_PULSES: act = pulses;
                  default:  act = high_cnt;
               endcase
               n_checks = n_checks + 1;
               if (sb[i].cyc < cyc) begin
                  n_fail = n_fail + 1;
                  $display("FAIL %s: check missed at cycle %0d (now %0d)", sb[i].nm, sb[i].cyc, cyc);
               end else if (act !== sb[i].exp) begin
                  n_fail = n_fail + 1;
                  $display("FAIL %s @%0d: got %02h expected %02h", sb[i].nm, cyc, act, sb[i].exp);
               end
               sb.delete(i);
            end
         end
      end
   end

   task automatic push(input int dc, input string nm, input int kind, input logic [7:0] e);
      chk_t c;
      c.cyc  = cyc + dc;
      c.nm   = nm;
      c.kind = kind;
      c.exp  = e;
      sb.push_back(c);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   logic [15:0] tv_joy [8];
   logic [7:0]  tv_exp [8];

   initial begin
      tv_joy[0] = 16'h000A; tv_exp[0] = 8'h02;
      tv_joy[1] = 16'h0004; tv_exp[1] = 8'h05;
      tv_joy[2] = 16'h0009; tv_exp[2] = 8'h08;
      tv_joy[3] = 16'h0001; tv_exp[3] = 8'h09;
      tv_joy[4] = 16'h0005; tv_exp[4] = 8'h04;
      tv_joy[5] = 16'h0006; tv_exp[5] = 8'h01;
      tv_joy[6] = 16'h000C; tv_exp[6] = 8'h00;
      tv_joy[7] = 16'h0000; tv_exp[7] = 8'h00;

      rst_n      = 1'b0;
      joy        = 16'hFFFF;
      joya       = 16'h0000;
      mod        = 8'd2;
      audiosel   = 8'd0;
      coin_watch = 1'b0;

      // reset state
      push(2, "reset_jb", K_JB, 8'h00);
      push(2, "reset_btn", K_BTN, 8'h00);
      push(2, "reset_rb", K_RB, 8'h00);
      step(3);
      joy   = 16'h0000;
      rst_n = 1'b1;
      push(1, "release_jb", K_JB, 8'h80);
      push(1, "release_btn", K_BTN, 8'h80);
      push(1, "release_rb", K_RB, 8'h00);
      step(2);

      // analog axis
      audiosel = 8'd1;
      joya     = 16'h7F80;
      push(1, "analog_x", K_BTN, 8'h00);
      step(1);
      audiosel = 8'd0;
      push(1, "analog_y", K_BTN, 8'hFF);
      push(1, "analog_jb", K_JB, 8'h80);
      step(2);

      // remap to Battlezone
      mod = 8'd0;
      push(1, "remap_jb", K_JB, 8'h00);
      push(1, "remap_btn", K_BTN, 8'h00);
      step(5);

      // 3-cycle glitch on fire never appears
      joy = 16'h0010;
      for (int k = 1; k <= 10; k++) push(k, "glitch_jb", K_JB, 8'h00);
      step(3);
      joy = 16'h0000;
      step(10);

      // held fire: visible exactly 7 cycles after application
      joy = 16'h0010;
      push(6, "fire_early", K_JB, 8'h00);
      push(7, "fire_jb", K_JB, 8'h10);
      push(7, "fire_btn", K_BTN, 8'h10);
      step(10);
      joy = 16'h0000;
      push(6, "fire_hold", K_JB, 8'h10);
      push(7, "fire_release", K_JB, 8'h00);
      step(10);

      // tread map vectors
      for (int t = 0; t < 8; t++) begin
         joy = tv_joy[t];
         push(8, "tread_jb", K_JB, tv_exp[t]);
         push(8, "tread_btn", K_BTN, tv_exp[t]);
         push(8, "tread_rb", K_RB, 8'h00);
         step(10);
      end

      // coin held 100 cycles gives one pulse; second press gives another
      coin_watch = 1'b1;
      joy = 16'h0080;
      step(99);
      push(1, "coin1_pulses", K_PULSES, 8'd1);
      push(1, "coin1_high", K_HIGH, 8'd8);
      step(1);
      joy = 16'h0000;
      step(30);
      joy = 16'h0080;
      step(30);
      joy = 16'h0000;
      step(20);
      push(1, "coin2_pulses", K_PULSES, 8'd2);
      push(1, "coin2_high", K_HIGH, 8'd16);
      step(2);

      // mod change during PULSE cancels it; no new pulse until release and re-press
      coin_watch = 1'b0;
      joy = 16'h0080;
      step(9);
      mod = 8'd2;
      for (int k = 1; k <= 10; k++) push(k, "modchg_rb_jb", K_JB, 8'h80);
      step(20);
      mod = 8'd0;
      for (int k = 1; k <= 20; k++) push(k, "modchg_bz_jb", K_JB, 8'h00);
      step(20);
      coin_watch = 1'b1;
      joy = 16'h0000;
      step(20);
      joy = 16'h0080;
      step(30);
      push(1, "coin3_pulses", K_PULSES, 8'd3);
      push(1, "coin3_high", K_HIGH, 8'd24);
      step(2);
      joy = 16'h0000;
      coin_watch = 1'b0;
      step(10);

      // Red Baron digital mapping and extra buttons
      mod = 8'd2;
      step(2);
      joy = 16'h0039;
      push(8, "rb_map_jb", K_JB, 8'hD6);
      push(8, "rb_map_rb", K_RB, 8'hC0);
      push(8, "rb_map_btn", K_BTN, 8'hFF);
      step(10);
      joy = 16'h0000;
      push(8, "rb_idle_jb", K_JB, 8'h80);
      push(8, "rb_idle_rb", K_RB, 8'h00);
      step(10);

      step(5);
      n_checks = n_checks + 1;
      if (sb.size() != 0) begin
         n_fail = n_fail + 1;
         $display("FAIL scoreboard_drain: got %0d pending entries expected 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
